// File: rtl/hazard_scoreboard.sv
// ID/EX interlock: per-register countdown of in-flight multi-cycle producers,
// stalling ID on RAW against any pending source or WAW against a slower older write.
module hazard_scoreboard #(
  parameter int NREGS   = 32,
  parameter int IDX_W   = 5,
  parameter int NSRC    = 2,
  parameter int MAX_LAT = 3,
  parameter int LAT_W   = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [NSRC*IDX_W-1:0]   id_rs_idx,
  input  logic [NSRC-1:0]         id_rs_used,
  input  logic [IDX_W-1:0]        id_rd_idx,
  input  logic                    id_rd_we,
  input  logic [LAT_W-1:0]        id_lat,
  input  logic                    pipe_freeze,
  input  logic                    flush,
  output logic                    HZ_U_stall,
  output logic [NSRC-1:0]         stall_src,
  output logic                    stall_waw,
  output logic [NREGS-1:0]        pending,
  output logic [CNT_W-1:0]        stall_cycles
);

  localparam logic [LAT_W:0] MAX_LAT_E = (LAT_W+1)'(MAX_LAT);

  logic [LAT_W-1:0] cnt [NREGS];
  logic [LAT_W:0]   lat_ext;
  logic [LAT_W-1:0] lat_c;
  logic [NSRC-1:0]  raw;
  logic             waw;
  logic             gate;
  logic             issue;
  logic             issue_wr;

  assign lat_ext = {1'b0, id_lat};
  assign lat_c   = (lat_ext > MAX_LAT_E) ? MAX_LAT_E[LAT_W-1:0] : id_lat;

  always_comb begin
    raw = '0;
    for (int k = 0; k < NSRC; k++) begin
      raw[k] = id_valid && id_rs_used[k] &&
               (id_rs_idx[k*IDX_W +: IDX_W] != '0) &&
               (cnt[id_rs_idx[k*IDX_W +: IDX_W]] != '0);
    end
  end

  // WAW only if the older write would land after this one
  assign waw = id_valid && id_rd_we && (id_rd_idx != '0) && (cnt[id_rd_idx] > lat_c);

  assign gate       = !flush && reset;
  assign HZ_U_stall = ((|raw) || waw) && gate;
  assign stall_src  = raw & {NSRC{gate}};
  assign stall_waw  = waw && gate;

  assign issue    = id_valid && !HZ_U_stall && !flush && !pipe_freeze;
  assign issue_wr = issue && id_rd_we && (id_rd_idx != '0) && (lat_c != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      stall_cycles <= '0;
    end else if (!pipe_freeze) begin
      for (int r = 1; r < NREGS; r++) begin
        if (issue_wr && (id_rd_idx == IDX_W'(r)))
          cnt[r] <= lat_c;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - LAT_W'(1);
      end
      if (HZ_U_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  always_comb begin
    pending = '0;
    for (int r = 1; r < NREGS; r++) pending[r] = (cnt[r] != '0);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised + directed bench for hazard_scoreboard with an integer reference
// model; the driver queues expected outputs, a negedge monitor compares them.
module tb_hazard_scoreboard;

  localparam int NREGS = 32;
  localparam int CNTW  = 4;
  localparam int SATV  = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [9:0]        id_rs_idx;
  logic [1:0]        id_rs_used;
  logic [4:0]        id_rd_idx;
  logic              id_rd_we;
  logic [1:0]        id_lat;
  logic              pipe_freeze;
  logic              flush;
  logic              HZ_U_stall;
  logic [1:0]        stall_src;
  logic              stall_waw;
  logic [NREGS-1:0]  pending;
  logic [CNTW-1:0]   stall_cycles;

  hazard_scoreboard #(.CNT_W(CNTW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_idx(id_rs_idx),
    .id_rs_used(id_rs_used), .id_rd_idx(id_rd_idx), .id_rd_we(id_rd_we),
    .id_lat(id_lat), .pipe_freeze(pipe_freeze), .flush(flush),
    .HZ_U_stall(HZ_U_stall), .stall_src(stall_src), .stall_waw(stall_waw),
    .pending(pending), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             stall;
    logic [1:0]       src;
    logic             waw;
    logic [NREGS-1:0] pend;
    logic [CNTW-1:0]  sc;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  int   mcnt[NREGS];
  int   msc = 0;
  logic last_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One ID cycle: drive inputs, queue the model's expectation, then age the model across the edge
  task automatic cyc(input bit v, input int s0, input int s1, input bit [1:0] used,
                     input int rd, input bit we, input int lat,
                     input bit frz, input bit fl, input bit rst);
    exp_t e;
    int   latc;
    bit   r0, r1, w, g, iss;
    id_valid = v; id_rs_idx = {5'(s1), 5'(s0)}; id_rs_used = used;
    id_rd_idx = 5'(rd); id_rd_we = we; id_lat = 2'(lat);
    pipe_freeze = frz; flush = fl; reset = rst;
    latc = (lat > 3) ? 3 : lat;
    r0 = v && used[0] && s0 != 0 && mcnt[s0] > 0;
    r1 = v && used[1] && s1 != 0 && mcnt[s1] > 0;
    w  = v && we && rd != 0 && mcnt[rd] > latc;
    g  = !fl && rst;
    e.stall = (r0 || r1 || w) && g;
    e.src   = {r1 && g, r0 && g};
    e.waw   = w && g;
    for (int r = 0; r < NREGS; r++) e.pend[r] = (mcnt[r] > 0);
    e.sc = CNTW'(msc);
    expq.push_back(e);
    @(negedge clk);
    last_stall = HZ_U_stall;
    @(posedge clk); #1;
    iss = v && !e.stall && !fl && !frz;
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) mcnt[r] = 0;
      msc = 0;
    end else if (!frz) begin
      for (int r = 1; r < NREGS; r++) begin
        if (iss && we && rd == r && latc != 0) mcnt[r] = latc;
        else if (mcnt[r] > 0) mcnt[r]--;
      end
      if (e.stall && msc < SATV) msc++;
    end
  endtask

  task automatic produce(input int rd, input int lat);
    cyc(1, 0, 0, 2'b00, rd, 1, lat, 0, 0, 1);
  endtask

  // Hold a consumer in ID until it issues; n = number of stall cycles seen
  task automatic hold(input string name, input int s0, input int s1, input bit [1:0] used,
                      input int rd, input bit we, input int lat, output int n);
    bit done = 0;
    n = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc(1, s0, s1, used, rd, we, lat, 0, 0, 1);
      if (last_stall) n++;
      else done = 1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_timeout: consumer still stalled after 20 cycles", name);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("stall",   HZ_U_stall,   e.stall);
        chk("src",     stall_src,    e.src);
        chk("waw",     stall_waw,    e.waw);
        chk("pending", pending,      e.pend);
        chk("scount",  stall_cycles, e.sc);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int n, sc0;
    for (int r = 0; r < NREGS; r++) mcnt[r] = 0;
    reset = 0; id_valid = 0; id_rs_idx = '0; id_rs_used = '0; id_rd_idx = '0;
    id_rd_we = 0; id_lat = '0; pipe_freeze = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1, 5, 5, 2'b11, 5, 1, 1, 0, 0, 0);

    // load-use: exactly one bubble
    produce(5, 1);
    hold("loaduse", 5, 0, 2'b01, 0, 0, 0, n);
    chk("loaduse_bubbles", n, 1);
    chk("loaduse_sc", stall_cycles, 1);

    // latency 3 on source 1
    produce(7, 3);
    hold("lat3", 0, 7, 2'b10, 0, 0, 0, n);
    chk("lat3_bubbles", n, 3);
    chk("lat3_pending", pending[7], 0);

    // r0 never tracked; unused operands never stall
    produce(0, 1);
    chk("r0_pending", pending, 0);
    produce(5, 1);
    hold("unused", 5, 5, 2'b00, 0, 0, 0, n);
    chk("unused_bubbles", n, 0);

    // WAW: ALU write must wait for the full drain, a lat-1 write until count <= 1
    produce(9, 3);
    hold("waw0", 0, 0, 2'b00, 9, 1, 0, n);
    chk("waw_lat0_bubbles", n, 3);
    produce(9, 3);
    hold("waw1", 0, 0, 2'b00, 9, 1, 1, n);
    chk("waw_lat1_bubbles", n, 2);
    repeat (2) cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);

    // freeze extends the stall and holds the statistics
    produce(5, 1);
    sc0 = int'(stall_cycles);
    repeat (4) cyc(1, 5, 0, 2'b01, 0, 0, 0, 1, 0, 1);
    chk("freeze_sc_held", stall_cycles, sc0);
    chk("freeze_cnt_held", pending[5], 1);
    hold("freeze", 5, 0, 2'b01, 0, 0, 0, n);
    chk("freeze_bubbles", n, 1);

    // flush beats the hazard and prevents issue
    produce(5, 1);
    cyc(1, 5, 0, 2'b01, 12, 1, 2, 0, 1, 1);
    chk("flush_noissue", pending[12], 0);

    // reset mid-countdown
    produce(3, 3);
    cyc(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    cyc(1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    chk("reset_pending", pending, 0);
    chk("reset_sc", stall_cycles, 0);

    // saturation: 7 rounds of 3 stalls on a 4-bit counter
    for (int i = 0; i < 7; i++) begin
      produce(4, 3);
      hold("sat", 4, 0, 2'b01, 0, 0, 0, n);
    end
    chk("sat_sc", stall_cycles, SATV);

    // random traffic over a small register window so hazards are dense
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) != 0,
          $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom),
          $urandom_range(0, 7), $urandom_range(0, 2) != 0, $urandom_range(0, 3),
          $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 59) != 0);
    end

    @(negedge clk);
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
